// File: rtl/key_pkg.sv
// Shared types and constants for the key debounce front-end: FSM state encoding,
// pin polarity and 50 MHz default timing constants.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_fsm_e;

    localparam logic KEY_ACTIVE_LOW = 1'b0;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
    localparam int DEF_LONG_CYCLES     = CLK_HZ;       // 1 s
    localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 5;   // 200 ms

    // Counter width for a count range of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_ctrl_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit; both flops
// load RST_VAL on synchronous reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: clocked state uses non-blocking assignments so both flops sample
    // their inputs on the same edge; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Key debounce controller: synchronised, debounced key level with press,
// release and long-press strobes plus a wrapping press counter.
// Optional auto-repeat after long press is enabled by defining KEY_REPEAT_EN.
module key_debounce_ctrl
    import key_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int   REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter logic KEY_ACTIVE      = KEY_ACTIVE_LOW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_state,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_cnt
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    // Hold counter must be able to sit at LONG_CYCLES once saturated.
    localparam int HW = cnt_width(LONG_CYCLES + 1);

    logic     sync_key;
    logic     key_act;
    key_fsm_e state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic     key_state_d, press_d, release_d, long_d;

    sync_2ff #(.RST_VAL(~KEY_ACTIVE)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (sync_key)
    );

    assign key_act = (sync_key == KEY_ACTIVE);

`ifdef KEY_REPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);
    logic [RW-1:0] rpt_q, rpt_d;
`else
    // Repeat period has no effect while auto-repeat is compiled out.
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        key_state_d = key_state;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_act) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_act) begin
                    state_d = IDLE;
                end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d     = PRESSED;
                    key_state_d = 1'b1;
                    press_d     = 1'b1;
                    hold_d      = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            PRESSED: begin
                if (hold_q != HW'(LONG_CYCLES)) hold_d = hold_q + HW'(1);
                if (hold_q == HW'(LONG_CYCLES - 1)) long_d = 1'b1;
                if (!key_act) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // Release bounce returns to PRESSED with hold_q untouched.
                if (key_act) begin
                    state_d = PRESSED;
                end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d     = IDLE;
                    key_state_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef KEY_REPEAT_EN
        // Repeat timer runs only while staying in PRESSED after the long press.
        rpt_d = '0;
        if (state_q == PRESSED && key_act && hold_q == HW'(LONG_CYCLES)) begin
            if (rpt_q == RW'(REPEAT_CYCLES - 1)) press_d = 1'b1;
            else                                 rpt_d   = rpt_q + RW'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hold_q        <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_cnt     <= '0;
`ifdef KEY_REPEAT_EN
            rpt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            key_state     <= key_state_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            press_cnt     <= press_cnt + 8'(press_d);
`ifdef KEY_REPEAT_EN
            rpt_q         <= rpt_d;
`endif
        end
    end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Scoreboard bench for key_debounce_ctrl: a run-length reference model queues
// expected strobes, a negedge monitor pops and compares them against the DUT.
module tb_key_debounce_ctrl;

    localparam int   DEB  = 16;
    localparam int   LONG = 64;
    localparam int   REP  = 20;
    localparam logic ACT  = 1'b0;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_in;
    logic       key_state, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_cnt;

    always #5 clk = ~clk;

    key_debounce_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .REPEAT_CYCLES   (REP),
        .KEY_ACTIVE      (ACT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_cnt     (press_cnt)
    );

    typedef struct {
        int cyc;
        int kind;
        int cnt;
        int level;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  last_press_cyc = -1;
    int  last_rel_cyc   = -1;
    int  last_long_cyc  = -1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic flag(input string msg);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    // Reference model: the debouncer sees the pin two edges late; a level is
    // accepted once seen on DEB+1 consecutive edges and differs from the
    // current debounced level. Hold time counts edges spent pressed.
    bit pin_q[$];
    bit seen, prev_seen, run_lvl, deb;
    int run, hold, rpt, m_cnt;

    task automatic push_ev(input int kind);
        ev_t e;
        e.cyc = cyc; e.kind = kind; e.cnt = m_cnt; e.level = int'(deb);
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pin_q.delete();
                deb = 0; run = 0; run_lvl = 0; prev_seen = 0;
                hold = 0; rpt = 0; m_cnt = 0;
            end else begin
                pin_q.push_back(key_in == ACT);
                if (pin_q.size() > 3) void'(pin_q.pop_front());
                seen = (pin_q.size() == 3) ? pin_q[0] : 1'b0;
                if (seen == run_lvl) run++;
                else begin
                    run_lvl = seen;
                    run     = 1;
                end
                if (run == DEB + 1 && run_lvl != deb) begin
                    deb = run_lvl;
                    if (deb) begin
                        m_cnt = (m_cnt + 1) % 256;
                        hold  = 0;
                        rpt   = 0;
                        push_ev(EV_PRESS);
                    end else begin
                        push_ev(EV_RELEASE);
                    end
                end else if (deb && prev_seen) begin
                    if (hold < LONG) begin
                        hold++;
                        if (hold == LONG) push_ev(EV_LONG);
                    end
`ifdef KEY_REPEAT_EN
                    else if (seen) begin
                        rpt++;
                        if (rpt == REP) begin
                            rpt   = 0;
                            m_cnt = (m_cnt + 1) % 256;
                            push_ev(EV_PRESS);
                        end
                    end
`endif
                end
                if (!(deb && seen)) rpt = 0;
                prev_seen = seen;
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT strobes, and flags any
    // expectation whose cycle has passed unmatched.
    ev_t mon_e;
    int  act_kind;
    initial begin
        forever begin
            @(negedge clk);
            if (press_pulse && release_pulse) flag("press_pulse and release_pulse high together");
            if (press_pulse || release_pulse || long_pulse) begin
                act_kind = press_pulse ? EV_PRESS : (release_pulse ? EV_RELEASE : EV_LONG);
                if (act_kind == EV_PRESS)   last_press_cyc = cyc;
                if (act_kind == EV_RELEASE) last_rel_cyc   = cyc;
                if (act_kind == EV_LONG)    last_long_cyc  = cyc;
                if (exp_q.size() == 0) begin
                    flag($sformatf("unexpected pulse kind %0d", act_kind));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ev_kind",      act_kind,       mon_e.kind);
                    check("ev_cycle",     cyc,            mon_e.cyc);
                    check("ev_press_cnt", int'(press_cnt), mon_e.cnt);
                    check("ev_key_state", int'(key_state), mon_e.level);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                flag($sformatf("missing pulse kind %0d due at cycle %0d", mon_e.kind, mon_e.cyc));
            end
        end
    end

    task automatic hold_key(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_key_state"},     int'(key_state),     0);
        check({tag, "_press_pulse"},   int'(press_pulse),   0);
        check({tag, "_release_pulse"}, int'(release_pulse), 0);
        check({tag, "_long_pulse"},    int'(long_pulse),    0);
        check({tag, "_press_cnt"},     int'(press_cnt),     0);
    endtask

    int t0, base;

    initial begin
        rst    = 1'b1;
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        hold_key(1'b1, 5);

        // Clean press and release
        t0 = cyc;
        hold_key(1'b0, 100);
        check("t1_press_latency", last_press_cyc - t0, DEB + 3);
        check("t1_long_delay",    last_long_cyc - last_press_cyc, LONG);
        check("t1_key_state",     int'(key_state), 1);
        check("t1_press_cnt",     int'(press_cnt), 1);
        check("t1_no_release",    last_rel_cyc, -1);
        hold_key(1'b1, 40);
        check("t1_released", int'(key_state), 0);

        // Press bounce: four short segments, then settle low
        for (int i = 0; i < 4; i++) hold_key((i % 2 == 0) ? 1'b0 : 1'b1, $urandom_range(3, 10));
        t0 = cyc;
        hold_key(1'b0, 100);
        check("t2_press_latency", last_press_cyc - t0, DEB + 3);
        check("t2_press_cnt",     int'(press_cnt), 2);

        // Release bounce
        hold_key(1'b1, 8);
        hold_key(1'b0, 4);
        t0 = cyc;
        hold_key(1'b1, 40);
        check("t3_release_latency", last_rel_cyc - t0, DEB + 3);
        check("t3_key_state",       int'(key_state), 0);
        check("t3_press_cnt",       int'(press_cnt), 2);

        // Random segments, some long enough to reach long press
        for (int i = 0; i < 80; i++) hold_key(1'($urandom_range(0, 1)), $urandom_range(1, 90));
        hold_key(1'b1, 40);
        check("t4_key_state", int'(key_state), int'(deb));
        check("t4_press_cnt", int'(press_cnt), m_cnt);

        // Counter wrap over 256 presses
        base = m_cnt;
        for (int i = 0; i < 256; i++) begin
            hold_key(1'b0, 20);
            hold_key(1'b1, 20);
        end
        check("t5_wrap_cnt", int'(press_cnt), base);
        hold_key(1'b0, 20);
        hold_key(1'b1, 20);
        check("t5_wrap_plus1", int'(press_cnt), (base + 1) % 256);

        // Reset while debouncing a press (counter at 10)
        key_in = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("t6_reset");
        rst = 1'b0;
        t0  = cyc;
        repeat (30) @(negedge clk);
        check("t6_press_latency", last_press_cyc - t0, DEB + 3);
        check("t6_press_cnt",     int'(press_cnt), 1);
        hold_key(1'b1, 40);

        // Long hold: auto-repeat when enabled, single press otherwise
        base = int'(press_cnt);
        hold_key(1'b0, DEB + 3 + 200);
`ifdef KEY_REPEAT_EN
        check("t7_repeat_cnt", int'(press_cnt), (base + 7) % 256);
`else
        check("t7_single_cnt", int'(press_cnt), (base + 1) % 256);
`endif
        hold_key(1'b1, 40);

        check("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
